tucanos_context_table: RTL and testbench

Process-context holder that sits directly downstream of the Tucanos watchdog and consumes its `jump_enabler` / `state_register` outputs. On a preemption, I/O wait or halt event it saves the interrupted process's program counter into a per-process slot and updates that process's status. It then issues a one-cycle PC load to the operating-system entry address. The OS later restores a chosen ready process through a request port, and the block drives that process's saved PC back to the fetch stage.

---
 rtl/tucanos_pkg.sv | 29 ++
 rtl/tucanos_context_table_if.sv | 33 +++
 rtl/tucanos_edge_detect.sv | 18 +
 rtl/tucanos_context_table.sv | 148 ++++++++++++++
 tb/tb_tucanos_context_table.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tucanos_pkg.sv
// Shared definitions for the Tucanos context table: process status encodings,
// watchdog event codes, the default OS entry address and the FSM state type.
package tucanos_pkg;

    // Per-process status, 2 bits each in process_status.
    typedef enum logic [1:0] {
        StatReady   = 2'b00,
        StatRunning = 2'b01,
        StatWaiting = 2'b10,
        StatHalted  = 2'b11
    } status_e;

    // Watchdog event codes carried in state_register[2:0].
    localparam logic [2:0] EV_QUANTUM_1 = 3'd1;
    localparam logic [2:0] EV_QUANTUM_2 = 3'd2;
    localparam logic [2:0] EV_QUANTUM_3 = 3'd3;
    localparam logic [2:0] EV_IO_WAIT   = 3'd4;
    localparam logic [2:0] EV_HALT      = 3'd5;

    localparam int unsigned DEFAULT_OS_ADDR = 256;

    typedef enum logic [1:0] {
        StIdle,
        StSave,
        StJumpOs,
        StRestore
    } ctx_state_e;

endpackage

// File: rtl/tucanos_context_table_if.sv
// Bundle of watchdog, OS and fetch-stage signals around the context table.
// master: the surrounding system (watchdog/CPU/OS) driving events and requests.
// slave:  the context table, returning PC loads and process bookkeeping.
interface tucanos_context_table_if #(
    parameter int unsigned PC_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  jump_enabler;
    logic [DATA_WIDTH-1:0] state_register;
    logic [PC_WIDTH-1:0]   program_counter;
    logic                  restore_request;
    logic [1:0]            restore_index;
    logic                  io_done;
    logic [1:0]            io_done_index;
    logic                  pc_load;
    logic [PC_WIDTH-1:0]   pc_target;
    logic [1:0]            current_process;
    logic [1:0]            next_hint;
    logic [5:0]            process_status;
    logic                  error;

    modport master (
        output jump_enabler, state_register, program_counter,
               restore_request, restore_index, io_done, io_done_index,
        input  pc_load, pc_target, current_process, next_hint, process_status, error
    );

    modport slave (
        input  jump_enabler, state_register, program_counter,
               restore_request, restore_index, io_done, io_done_index,
        output pc_load, pc_target, current_process, next_hint, process_status, error
    );
endinterface

// File: rtl/tucanos_edge_detect.sv
// One-bit rising-edge detector.
// Ports: clock, reset (async, active-high), level_i (sampled level),
//        rise_o (high while level_i is high and was low the previous cycle).
module tucanos_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);
    logic prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= level_i;
    end

    assign rise_o = level_i & ~prev_q;
endmodule

// File: rtl/tucanos_context_table.sv
// Process-context holder behind the Tucanos watchdog. Saves the interrupted
// process PC and status on a watchdog event, jumps to the OS, and later
// restores a ready process's saved PC on request.
// Ports: clock, reset (async, active-high), bus (slave side of
//        tucanos_context_table_if: watchdog/OS inputs, pc_load/pc_target to
//        fetch, current_process, next_hint, process_status, error).
module tucanos_context_table
    import tucanos_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = 12,
    parameter int unsigned         DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] OS_ADDR    = PC_WIDTH'(DEFAULT_OS_ADDR)
) (
    input  logic                         clock,
    input  logic                         reset,
    tucanos_context_table_if.slave       bus
);
    ctx_state_e          state_q, state_d;
    logic [1:0]          cur_q, cur_d;
    logic [1:0]          hint_q, hint_d;
    logic                err_q, err_d;
    logic [PC_WIDTH-1:0] pc_lat_q, pc_lat_d;
    logic [2:0]          code_lat_q, code_lat_d;
    logic [1:0]          rst_idx_q, rst_idx_d;
    status_e             status_q [1:3];
    status_e             status_d [1:3];
    logic [PC_WIDTH-1:0] saved_pc_q [1:3];
    logic [PC_WIDTH-1:0] saved_pc_d [1:3];
    logic                event_rise;

    // Only the low three bits carry an event code.
    logic [DATA_WIDTH-4:0] unused_state_bits;
    assign unused_state_bits = bus.state_register[DATA_WIDTH-1:3];

    tucanos_edge_detect u_jump_edge (
        .clock   (clock),
        .reset   (reset),
        .level_i (bus.jump_enabler),
        .rise_o  (event_rise)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        hint_d     = hint_q;
        err_d      = err_q;
        pc_lat_d   = pc_lat_q;
        code_lat_d = code_lat_q;
        rst_idx_d  = rst_idx_q;
        status_d   = status_q;
        saved_pc_d = saved_pc_q;

        // Applied first so a SAVE write to the same slot overrides it.
        if (bus.io_done && bus.io_done_index != 2'd0 &&
            status_q[bus.io_done_index] == StatWaiting) begin
            status_d[bus.io_done_index] = StatReady;
        end

        unique case (state_q)
            StIdle: begin
                if (event_rise) begin
                    // Any simultaneous restore is dropped; the OS re-issues it.
                    if (cur_q != 2'd0) begin
                        state_d    = StSave;
                        pc_lat_d   = bus.program_counter;
                        code_lat_d = bus.state_register[2:0];
                    end
                end else if (bus.restore_request) begin
                    if (bus.restore_index != 2'd0 &&
                        status_q[bus.restore_index] == StatReady) begin
                        state_d                     = StRestore;
                        rst_idx_d                   = bus.restore_index;
                        cur_d                       = bus.restore_index;
                        status_d[bus.restore_index] = StatRunning;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSave: begin
                saved_pc_d[cur_q] = pc_lat_q;
                case (code_lat_q)
                    EV_QUANTUM_1, EV_QUANTUM_2, EV_QUANTUM_3: begin
                        status_d[cur_q] = StatReady;
                        hint_d          = code_lat_q[1:0];
                    end
                    EV_IO_WAIT: status_d[cur_q] = StatWaiting;
                    EV_HALT:    status_d[cur_q] = StatHalted;
                    default:    status_d[cur_q] = StatReady;
                endcase
                cur_d   = 2'd0;
                state_d = StJumpOs;
            end
            StJumpOs:  state_d = StIdle;
            StRestore: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cur_q      <= 2'd0;
            hint_q     <= 2'd0;
            err_q      <= 1'b0;
            pc_lat_q   <= '0;
            code_lat_q <= 3'd0;
            rst_idx_q  <= 2'd0;
            for (int i = 1; i <= 3; i++) begin
                status_q[i]   <= StatReady;
                saved_pc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            hint_q     <= hint_d;
            err_q      <= err_d;
            pc_lat_q   <= pc_lat_d;
            code_lat_q <= code_lat_d;
            rst_idx_q  <= rst_idx_d;
            status_q   <= status_d;
            saved_pc_q <= saved_pc_d;
        end
    end

    // pc_load is decoded from state, so it is a single cycle per load.
    always_comb begin
        bus.pc_load   = 1'b0;
        bus.pc_target = '0;
        unique case (state_q)
            StJumpOs: begin
                bus.pc_load   = 1'b1;
                bus.pc_target = OS_ADDR;
            end
            StRestore: begin
                bus.pc_load   = 1'b1;
                bus.pc_target = saved_pc_q[rst_idx_q];
            end
            default: ;
        endcase
    end

    assign bus.current_process = cur_q;
    assign bus.next_hint       = hint_q;
    assign bus.process_status  = {status_q[3], status_q[2], status_q[1]};
    assign bus.error           = err_q;

endmodule

// File: tb/tb_tucanos_context_table.sv
module tb_tucanos_context_table;

    typedef struct {
        logic [11:0] target;
        logic [1:0]  cur;
        logic [5:0]  status;
        logic [1:0]  hint;
        logic        err;
    } load_t;

    logic  clock;
    logic  reset;
    int    checks;
    int    errors;
    load_t exp_q [$];

    tucanos_context_table_if #(.PC_WIDTH(12), .DATA_WIDTH(32)) ifc ();

    tucanos_context_table #(
        .PC_WIDTH   (12),
        .DATA_WIDTH (32),
        .OS_ADDR    (12'd256)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_load(input logic [11:0] t, input logic [1:0] c, input logic [5:0] s,
                               input logic [1:0] h, input logic e);
        load_t x;
        x.target = t;
        x.cur    = c;
        x.status = s;
        x.hint   = h;
        x.err    = e;
        exp_q.push_back(x);
    endtask

    task automatic restore(input logic [1:0] idx);
        ifc.restore_request = 1'b1;
        ifc.restore_index   = idx;
        tick();
        ifc.restore_request = 1'b0;
    endtask

    task automatic fire_event(input logic [11:0] pc, input logic [31:0] code, input int hold);
        ifc.program_counter = pc;
        ifc.state_register  = code;
        ifc.jump_enabler    = 1'b1;
        ticks(hold);
        ifc.jump_enabler    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        tick();
    endtask

    // Monitor: every pc_load must match the oldest expected load.
    always @(negedge clock) begin
        if (!reset && ifc.pc_load) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pc_load", 32'(ifc.pc_target), 32'hFFFF_FFFF);
            end else begin
                load_t x;
                x = exp_q.pop_front();
                check("load_target", 32'(ifc.pc_target), 32'(x.target));
                check("load_current", 32'(ifc.current_process), 32'(x.cur));
                check("load_status", 32'(ifc.process_status), 32'(x.status));
                check("load_hint", 32'(ifc.next_hint), 32'(x.hint));
                check("load_error", 32'(ifc.error), 32'(x.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ifc.jump_enabler    = 1'b0;
        ifc.state_register  = '0;
        ifc.program_counter = '0;
        ifc.restore_request = 1'b0;
        ifc.restore_index   = 2'd0;
        ifc.io_done         = 1'b0;
        ifc.io_done_index   = 2'd0;
        ticks(2);
        reset = 1'b0;
        tick();

        check("rst_status", 32'(ifc.process_status), 32'h0);
        check("rst_pc_load", 32'(ifc.pc_load), 32'h0);
        check("rst_pc_target", 32'(ifc.pc_target), 32'h0);
        check("rst_current", 32'(ifc.current_process), 32'h0);
        check("rst_hint", 32'(ifc.next_hint), 32'h0);
        check("rst_error", 32'(ifc.error), 32'h0);

        // Restore process 2 with its reset PC.
        expect_load(12'h000, 2'd2, 6'b000100, 2'd0, 1'b0);
        restore(2'd2);
        ticks(3);

        // Quantum expiry, then restore the saved PC.
        expect_load(12'h100, 2'd0, 6'b000000, 2'd3, 1'b0);
        fire_event(12'h0A3, 32'd3, 1);
        ticks(4);
        expect_load(12'h0A3, 2'd2, 6'b000100, 2'd3, 1'b0);
        restore(2'd2);
        ticks(3);

        // Hand the CPU to process 1.
        expect_load(12'h100, 2'd0, 6'b000000, 2'd1, 1'b0);
        fire_event(12'h011, 32'd1, 1);
        ticks(4);
        expect_load(12'h000, 2'd1, 6'b000001, 2'd1, 1'b0);
        restore(2'd1);
        ticks(3);

        // I/O wait: restore fails until io_done.
        expect_load(12'h100, 2'd0, 6'b000010, 2'd1, 1'b0);
        fire_event(12'h055, 32'd4, 1);
        ticks(4);
        restore(2'd1);
        check("io_wait_error", 32'(ifc.error), 32'h1);
        check("io_wait_status", 32'(ifc.process_status), 32'b000010);
        ifc.io_done       = 1'b1;
        ifc.io_done_index = 2'd1;
        tick();
        ifc.io_done = 1'b0;
        check("io_done_status", 32'(ifc.process_status), 32'b000000);
        expect_load(12'h055, 2'd1, 6'b000001, 2'd1, 1'b1);
        restore(2'd1);
        ticks(3);

        // Held jump_enabler with halt code yields a single load.
        do_reset();
        check("rst2_error", 32'(ifc.error), 32'h0);
        expect_load(12'h000, 2'd1, 6'b000001, 2'd0, 1'b0);
        restore(2'd1);
        ticks(3);
        expect_load(12'h100, 2'd0, 6'b000011, 2'd0, 1'b0);
        fire_event(12'h077, 32'd5, 5);
        ticks(3);
        check("halt_status", 32'(ifc.process_status), 32'b000011);
        check("halt_error_clear", 32'(ifc.error), 32'h0);
        ifc.io_done       = 1'b1;
        ifc.io_done_index = 2'd1;
        tick();
        ifc.io_done = 1'b0;
        check("halt_io_done", 32'(ifc.process_status), 32'b000011);
        restore(2'd1);
        check("halt_restore_error", 32'(ifc.error), 32'h1);
        ticks(4);
        check("error_sticky", 32'(ifc.error), 32'h1);

        // Event and restore in the same cycle: only the OS jump happens.
        do_reset();
        expect_load(12'h000, 2'd3, 6'b010000, 2'd0, 1'b0);
        restore(2'd3);
        ticks(3);
        expect_load(12'h100, 2'd0, 6'b000000, 2'd2, 1'b0);
        ifc.restore_request = 1'b1;
        ifc.restore_index   = 2'd1;
        fire_event(12'h0C4, 32'd2, 1);
        ifc.restore_request = 1'b0;
        ticks(4);
        check("collide_current", 32'(ifc.current_process), 32'h0);
        check("collide_error", 32'(ifc.error), 32'h0);
        expect_load(12'h0C4, 2'd3, 6'b010000, 2'd2, 1'b0);
        restore(2'd3);
        ticks(3);

        // Reset while in SAVE leaves the slot untouched.
        fire_event(12'h0EE, 32'd4, 1);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_status", 32'(ifc.process_status), 32'h0);
        check("midrst_current", 32'(ifc.current_process), 32'h0);
        check("midrst_pc_load", 32'(ifc.pc_load), 32'h0);
        check("midrst_hint", 32'(ifc.next_hint), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        expect_load(12'h000, 2'd3, 6'b010000, 2'd0, 1'b0);
        restore(2'd3);
        ticks(4);

        check("pending_loads", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
